// File: rtl/md_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// master: EX-stage issue side; slave: md_unit.
interface md_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             abort;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             busy_any;
  logic             done;

  modport master (
    output start, op, src_a, src_b, wr_hi, wr_lo, wr_data, abort,
    input  hi, lo, busy, busy_any, done
  );

  modport slave (
    input  start, op, src_a, src_b, wr_hi, wr_lo, wr_data, abort,
    output hi, lo, busy, busy_any, done
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div unit owning HI/LO. The result is computed at start and
// parked in pending registers; a latency counter decides when it commits.
//
// state   | meaning
// IDLE    | cnt=0, accepts start or mthi/mtlo writes
// RUN     | cnt>0, result pending; commits when cnt goes 1->0
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave md
);
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic             r_done;
  logic             w_launch, w_commit, w_drop, w_wr_hi_en, w_wr_lo_en;

  logic [2*WIDTH-1:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx, w_prod_s, w_prod_u;
  logic [WIDTH-1:0]   w_div_b, w_quot_s, w_rem_s, w_quot_u, w_rem_u;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;
  logic               w_div_zero, w_div_ovf;
  logic [CW-1:0]      w_lat;

  // Operands widened first so the low 2*WIDTH bits of the product are exact.
  assign w_a_sx   = {{WIDTH{md.src_a[WIDTH-1]}}, md.src_a};
  assign w_b_sx   = {{WIDTH{md.src_b[WIDTH-1]}}, md.src_b};
  assign w_a_zx   = {{WIDTH{1'b0}}, md.src_a};
  assign w_b_zx   = {{WIDTH{1'b0}}, md.src_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = w_a_zx * w_b_zx;

  // Zero and MIN/-1 divisors are steered to 1 so the divider never sees them.
  assign w_div_zero = (md.src_b == '0);
  assign w_div_ovf  = (md.src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (md.src_b == '1);
  assign w_div_b    = (w_div_zero || w_div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : md.src_b;
  assign w_quot_s   = $signed(md.src_a) / $signed(w_div_b);
  assign w_rem_s    = $signed(md.src_a) % $signed(w_div_b);
  assign w_quot_u   = md.src_a / w_div_b;
  assign w_rem_u    = md.src_a % w_div_b;

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (md.op)
      2'd0: {w_res_hi, w_res_lo} = w_prod_s;
      2'd1: {w_res_hi, w_res_lo} = w_prod_u;
      2'd2: begin
        if (w_div_zero) begin
          w_res_hi = md.src_a;
          w_res_lo = '1;
        end else if (w_div_ovf) begin
          w_res_hi = '0;
          w_res_lo = md.src_a;
        end else begin
          w_res_hi = w_rem_s;
          w_res_lo = w_quot_s;
        end
      end
      default: begin
        if (w_div_zero) begin
          w_res_hi = md.src_a;
          w_res_lo = '1;
        end else begin
          w_res_hi = w_rem_u;
          w_res_lo = w_quot_u;
        end
      end
    endcase
  end

  assign w_lat = md.op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    w_wr_hi_en  = 1'b0;
    w_wr_lo_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md.start && !md.abort) begin
          w_launch    = 1'b1;
          w_cnt_nxt   = w_lat;
          w_state_nxt = ST_RUN;
        end else if (!md.start) begin
          w_wr_hi_en = md.wr_hi;
          w_wr_lo_en = md.wr_lo;
        end
      end
      default: begin
        if (md.abort) begin
          w_drop      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_commit;
      if (w_launch) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
      end else if (w_drop) begin
        r_pend_hi <= '0;
        r_pend_lo <= '0;
      end
      if (w_commit)        r_hi <= r_pend_hi;
      else if (w_wr_hi_en) r_hi <= md.wr_data;
      if (w_commit)        r_lo <= r_pend_lo;
      else if (w_wr_lo_en) r_lo <= md.wr_data;
    end
  end

  assign md.hi       = r_hi;
  assign md.lo       = r_lo;
  assign md.busy     = (r_state == ST_RUN);
  assign md.busy_any = md.start | md.busy;
  assign md.done     = r_done;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboarded bench for md_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_md_unit;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if #(.WIDTH(W)) bus ();
  md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: mult via 64-bit products, div via magnitudes with sign fix-up.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int ia, ib;
    longint sa, sb, ma, mb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    ia = a; ib = b; sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb;
          r = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset) prev_done = 1'b0;
      else begin
        if (bus.done) begin
          check("done_one_cycle", 64'(prev_done), 64'd0);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: hi=%h lo=%h with no result expected", bus.hi, bus.lo);
          end else begin
            e = exp_q.pop_front();
            check("result_hi", 64'(bus.hi), 64'(e[63:32]));
            check("result_lo", 64'(bus.lo), 64'(e[31:0]));
          end
        end
        prev_done = bus.done;
      end
    end
  end

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    if (push) exp_q.push_back(ref_md(op, a, b));
    #1 check("busy_any_start", 64'(bus.busy_any), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_op(input int exp_cycles);
    int n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'(exp_cycles));
    check("done_at_busy_fall", 64'(bus.done), 64'd1);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    launch(op, a, b, 1'b1);
    finish_op(op[1] ? DL : ML);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
    bus.wr_hi = 0; bus.wr_lo = 0; bus.wr_data = 0; bus.abort = 0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy_any", 64'(bus.busy_any), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", 64'(bus.lo), 64'd1);
    do_op(2'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFA);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("div_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    do_op(2'd3, 32'd7, 32'd0);
    check("divu0_hi", 64'(bus.hi), 64'd7);
    check("divu0_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_hi", 64'(bus.hi), 64'd0);
    check("divovf_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);

    bus.wr_hi = 1; bus.wr_data = 32'h1234_5678;
    @(negedge clk);
    bus.wr_hi = 0;
    check("mthi", 64'(bus.hi), 64'h1234_5678);
    bus.wr_lo = 1; bus.wr_data = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.wr_lo = 0;
    check("mtlo", 64'(bus.lo), 64'h9ABC_DEF0);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);

    launch(2'd0, 32'd3, 32'd4, 1'b1);
    bus.wr_hi = 1; bus.wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.wr_hi = 0;
    check("wr_hi_busy_ignored", 64'(bus.hi), 64'h1234_5678);
    finish_op(ML - 1);
    check("wr_busy_commit_lo", 64'(bus.lo), 64'd12);

    bus.wr_hi = 1; bus.wr_data = 32'h11;
    @(negedge clk);
    bus.wr_hi = 0; bus.wr_lo = 1; bus.wr_data = 32'h22;
    @(negedge clk);
    bus.wr_lo = 0;
    launch(2'd0, 32'd9, 32'd9, 1'b0);
    repeat (2) @(negedge clk);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'h11);
    check("abort_lo", 64'(bus.lo), 64'h22);
    repeat (6) @(negedge clk);

    bus.abort = 1; bus.start = 1; bus.op = 2'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    bus.abort = 0; bus.start = 0;
    check("abort_start_busy", 64'(bus.busy), 64'd0);
    repeat (DL + 2) @(negedge clk);
    check("abort_start_hi", 64'(bus.hi), 64'h11);

    launch(2'd3, 32'd100, 32'd7, 1'b1);
    bus.start = 1; bus.op = 2'd1; bus.src_a = 32'd5; bus.src_b = 32'd6;
    @(negedge clk);
    bus.start = 0;
    finish_op(DL - 1);
    check("ign_start_hi", 64'(bus.hi), 64'd2);
    check("ign_start_lo", 64'(bus.lo), 64'd14);
    repeat (ML + 2) @(negedge clk);

    launch(2'd0, 32'd7, 32'd9, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    repeat (ML + 2) @(negedge clk);
    check("midrst_no_commit", 64'(bus.lo), 64'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
